// File: rtl/mem_stage_mc.sv
// MEM stage: resolves branches from EX flags and runs a req/ack data-memory access,
// stalling upstream while the access is in flight and aborting it after TIMEOUT cycles.
module mem_stage_mc #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic [2:0]    M,
  input  logic [1:0]    WB_in,
  input  logic [2:0]    flags_in,
  input  logic [2:0]    cond,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] PCbranch_in,
  input  logic [DW-1:0] ALU_in,
  output logic          stall,
  output logic          Branch,
  output logic [AW-1:0] PCbranch,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          wb_valid,
  output logic [1:0]    wb_ctrl,
  output logic [DW-1:0] wb_rdata,
  output logic [DW-1:0] wb_alu,
  output logic          wb_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_q, req_d, we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [1:0]      wbl_q, wbl_d;
  logic [DW-1:0]   alul_q, alul_d;
  logic            wbv_q, wbv_d, err_q, err_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic [DW-1:0]   rdata_q, rdata_d, alu_q, alu_d;
  logic            cond_met;

  logic ov, neg, zr;
  assign {ov, neg, zr} = flags_in;

  always_comb begin
    cond_met = 1'b0;
    unique case (cond)
      3'b000: cond_met = !zr;
      3'b001: cond_met = zr;
      3'b010: cond_met = !zr && !neg;
      3'b011: cond_met = neg;
      3'b100: cond_met = zr || !neg;
      3'b101: cond_met = neg || zr;
      3'b110: cond_met = ov;
      default: cond_met = 1'b1;
    endcase
  end

  assign Branch   = valid_in & M[2] & (state_q == IDLE) & cond_met;
  assign stall    = (state_q == ACCESS);
  assign PCbranch = PCbranch_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wbl_d   = wbl_q;
    alul_d  = alul_q;
    wbv_d   = 1'b0;
    err_d   = err_q;
    ctrl_d  = ctrl_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (M[1:0] == 2'b00) begin
            wbv_d   = 1'b1;
            ctrl_d  = WB_in;
            alu_d   = ALU_in;
            rdata_d = '0;
            err_d   = 1'b0;
          end else begin
            // M=11 falls through as a write
            state_d = ACCESS;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = M[1];
            addr_d  = addr;
            wdata_d = wdata;
            wbl_d   = WB_in;
            alul_d  = ALU_in;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
          req_d   = 1'b0;
          wbv_d   = 1'b1;
          ctrl_d  = wbl_q;
          alu_d   = alul_q;
          rdata_d = we_q ? '0 : mem_rdata;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          // abort: report the error but suppress the register write
          state_d = IDLE;
          cnt_d   = '0;
          req_d   = 1'b0;
          wbv_d   = 1'b1;
          ctrl_d  = 2'b00;
          alu_d   = alul_q;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wbl_q   <= '0;
      alul_q  <= '0;
      wbv_q   <= 1'b0;
      err_q   <= 1'b0;
      ctrl_q  <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wbl_q   <= wbl_d;
      alul_q  <= alul_d;
      wbv_q   <= wbv_d;
      err_q   <= err_d;
      ctrl_q  <= ctrl_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wb_valid  = wbv_q;
  assign wb_ctrl   = ctrl_q;
  assign wb_rdata  = rdata_q;
  assign wb_alu    = alu_q;
  assign wb_err    = err_q;

endmodule
